// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the instruction/data BRAM port arbiter.
package mips_mem_pkg;

    localparam int ADDR_W_DEF         = 16;
    localparam int DATA_W_DEF         = 32;
    localparam int MAX_CPU_STREAK_DEF = 4;
    // Wide enough for the largest legal streak limit (15).
    localparam int STREAK_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        CPU_WR = 2'd2,
        DBG_RD = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rd_pipe.sv
// Read-return tracker: an RD_LAT-deep valid/owner shift register. An entry
// is launched in the grant cycle and reaches the last stage in the cycle
// whose closing edge is where mem_rdata must be sampled.
module mem_rd_pipe
    import mips_mem_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    input  logic launch_dbg,
    output logic sample,
    output logic sample_dbg
);

    logic [RD_LAT:1] vld;
    logic [RD_LAT:1] own_dbg;

    // Shift the read token one stage per cycle; reset drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= '0;
            own_dbg <= '0;
        end else begin
            vld[1]     <= launch;
            own_dbg[1] <= launch_dbg;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld[i]     <= vld[i-1];
                own_dbg[i] <= own_dbg[i-1];
            end
        end
    end

    assign sample     = vld[RD_LAT];
    assign sample_dbg = own_dbg[RD_LAT];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port BRAM between the CPU (read/write) and the
// debug/inference read port. One access outstanding at a time; the CPU has
// priority but debug is forced after MAX_CPU_STREAK back-to-back CPU grants.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int RD_LAT         = 2,
    parameter int MAX_CPU_STREAK = MAX_CPU_STREAK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

    arb_state_t          state;
    logic [STREAK_W-1:0] streak;
    logic                sample;
    logic                sample_dbg;
    logic                launch;
    logic                launch_dbg;
    logic                dbg_wins;

    // Debug wins when the CPU is quiet or has used up its streak.
    assign dbg_wins   = dbg_req && (!cpu_req || (streak == STREAK_MAX));

    // mem_en is high only in the grant cycle, so it marks the read launch.
    assign launch     = mem_en && !mem_we;
    assign launch_dbg = (state == DBG_RD);

    mem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .launch     (launch),
        .launch_dbg (launch_dbg),
        .sample     (sample),
        .sample_dbg (sample_dbg)
    );

    // Arbitration FSM with registered grant/BRAM outputs and the streak counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            cpu_gnt   <= 1'b0;
            dbg_gnt   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            cpu_gnt <= 1'b0;
            dbg_gnt <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbg_wins) begin
                        state    <= DBG_RD;
                        dbg_gnt  <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_addr <= dbg_addr;
                        busy     <= 1'b1;
                        streak   <= '0;
                    end else if (cpu_req) begin
                        state     <= cpu_we ? CPU_WR : CPU_RD;
                        cpu_gnt   <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        busy      <= 1'b1;
                        // Only grants that make debug wait count toward the streak.
                        if (!dbg_req)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 1'b1;
                    end else begin
                        busy <= 1'b0;
                        if (!dbg_req)
                            streak <= '0;
                    end
                end
                CPU_WR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                CPU_RD, DBG_RD: begin
                    // Leave as the data is captured so IDLE lines up with rvalid.
                    if (sample) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Steer the sampled BRAM data to its owner; rdata holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= sample && !sample_dbg;
            dbg_rvalid <= sample && sample_dbg;
            if (sample && !sample_dbg)
                cpu_rdata <= mem_rdata;
            if (sample && sample_dbg)
                dbg_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with RD_LAT=2, MAX_CPU_STREAK=4 and a
// behavioural two-cycle BRAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req;
    logic [15:0] dbg_addr;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(2), .MAX_CPU_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Two-cycle BRAM: data for an enable in cycle C is on mem_rdata in C+2.
    logic [31:0] bram [0:65535];
    logic [31:0] q1, q2;
    always @(posedge clk) begin
        if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
        if (mem_en) q1 <= bram[mem_addr];
        q2 <= q1;
    end
    assign mem_rdata = q2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One CPU access from an idle arbiter, checked cycle by cycle.
    task automatic cpu_access(input string tag, input logic we, input logic [15:0] a,
                              input logic [31:0] d, input logic [31:0] exp);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        chk({tag, "_gnt"},   cpu_gnt, 1);
        chk({tag, "_en"},    mem_en, 1);
        chk({tag, "_we"},    mem_we, we);
        chk({tag, "_addr"},  mem_addr, a);
        chk({tag, "_busyC"}, busy, 1);
        if (we) chk({tag, "_wdata"}, mem_wdata, d);
        cpu_req = 1'b0;
        @(negedge clk);
        chk({tag, "_gnt_off"}, {cpu_gnt, mem_en, mem_we}, 0);
        if (we) begin
            chk({tag, "_busy_wr_end"}, busy, 0);
        end else begin
            chk({tag, "_busyC1"}, {busy, cpu_rvalid}, 2'b10);
            @(negedge clk);
            chk({tag, "_busyC2"}, {busy, cpu_rvalid}, 2'b10);
            @(negedge clk);
            chk({tag, "_rvalid"}, {busy, cpu_rvalid}, 2'b01);
            chk({tag, "_rdata"},  cpu_rdata, exp);
            @(negedge clk);
            chk({tag, "_rvalid_pulse"}, cpu_rvalid, 0);
            chk({tag, "_rdata_hold"},   cpu_rdata, exp);
        end
    endtask

    int          seq[$];
    int          cpu_rv_cnt;
    logic [31:0] tmp;

    initial begin
        for (int i = 0; i < 65536; i++) bram[i] = 32'h0;
        bram[16'h0010] = 32'h2108000A;
        bram[16'h189D] = 32'h0BADF00D;
        bram[16'h0030] = 32'h13572468;
        q1 = '0; q2 = '0;
        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_addr = 0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy}, 0);
        chk("reset_data", {cpu_rdata, dbg_rdata}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1/2: CPU read, write, read-back
        cpu_access("rd10", 1'b0, 16'h0010, 32'h0, 32'h2108000A);
        cpu_access("wr20", 1'b1, 16'h0020, 32'hDEADBEEF, 32'h0);
        cpu_access("rd20", 1'b0, 16'h0020, 32'h0, 32'hDEADBEEF);

        // 3: debug read with CPU idle
        dbg_req = 1'b1; dbg_addr = 16'd6301;
        @(negedge clk);
        chk("dbg_gnt",  {dbg_gnt, cpu_gnt, mem_en, mem_we}, 4'b1010);
        chk("dbg_addr", mem_addr, 16'h189D);
        dbg_req = 1'b0;
        cpu_rv_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            chk("dbg_wait", {dbg_gnt, dbg_rvalid, busy}, 3'b001);
            cpu_rv_cnt += int'(cpu_rvalid);
        end
        @(negedge clk);
        chk("dbg_rvalid", {dbg_rvalid, busy}, 2'b10);
        chk("dbg_rdata",  dbg_rdata, 32'h0BADF00D);
        cpu_rv_cnt += int'(cpu_rvalid);
        chk("dbg_no_cpu_rvalid", cpu_rv_cnt, 0);
        chk("dbg_cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // 4: fairness -- continuous CPU reads with debug pending
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        dbg_req = 1'b1; dbg_addr = 16'h0010;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cpu_gnt) seq.push_back(0);
            if (dbg_gnt) begin seq.push_back(1); dbg_req = 1'b0; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        chk("fair_count", seq.size() >= 6, 1);
        for (int k = 0; k < 6; k++)
            chk($sformatf("fair_seq%0d", k), seq[k], (k == 4) ? 1 : 0);
        chk("fair_dbg_data", dbg_rdata, 32'h2108000A);
        repeat (6) @(negedge clk);
        chk("fair_idle", busy, 0);

        // 5: simultaneous requests with streak clear
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        dbg_req = 1'b1; dbg_addr = 16'h0030;
        @(negedge clk);
        chk("sim_cpu_first", {cpu_gnt, dbg_gnt}, 2'b10);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("sim_cpu_rv", {cpu_rvalid, dbg_gnt, busy}, 3'b100);
        @(negedge clk);
        chk("sim_dbg_next", {dbg_gnt, cpu_gnt}, 2'b10);
        dbg_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("sim_dbg_rdata", {dbg_rvalid, dbg_rdata}, {1'b1, 32'h13572468});
        @(negedge clk);

        // 6: reset in C+1 of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        @(negedge clk);
        chk("rst_pre_gnt", cpu_gnt, 1);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_outs", {cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy}, 0);
        tmp = cpu_rdata;
        chk("rst_async_rdata", tmp, 0);
        chk("rst_async_addr", {mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        cpu_rv_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            cpu_rv_cnt += int'(cpu_rvalid);
        end
        chk("rst_no_rvalid", cpu_rv_cnt, 0);
        chk("rst_idle", busy, 0);
        cpu_access("post_rst", 1'b0, 16'h0010, 32'h0, 32'h2108000A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
